// File: rtl/xf_matrix_memory.sv
// xf_matrix_memory
// 256 x 32-bit transform matrix store. Words arrive in bursts on the load
// port. The position transform stage reads whole 4-word rows with
// 1-cycle latency. Reads take priority over load beats.
// Optional feature: define XF_MATMEM_READBACK_EN to add a single-word
// readback port (rbAddr/rbEnable/rbData/rbValid). That port ranks below
// row reads.
module xf_matrix_memory (
  input  logic         clk,
  input  logic         resetn,
  input  logic         loadStart,
  input  logic [7:0]   loadAddr,
  input  logic [3:0]   loadCount,
  output logic         loadBusy,
  input  logic [31:0]  loadData,
  input  logic         loadValid,
  output logic         loadReady,
  input  logic [6:0]   posmatAddr,
  input  logic         posmatEnable,
`ifdef XF_MATMEM_READBACK_EN
  input  logic [7:0]   rbAddr,
  input  logic         rbEnable,
  output logic [31:0]  rbData,
  output logic         rbValid,
`endif
  output logic [127:0] posmatData,
  output logic         posmatValid
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOAD = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [7:0]   wr_ptr_q, wr_ptr_d;
  logic [3:0]   beat_cnt_q, beat_cnt_d;
  logic [127:0] posmat_data_q, posmat_data_d;
  logic         posmat_valid_q, posmat_valid_d;
  logic [31:0]  mem_q [256];

  logic         read_stall;
  logic         load_ready;
  logic         beat_accept;
  logic [7:0]   row_base;

`ifdef XF_MATMEM_READBACK_EN
  logic [31:0]  rb_data_q, rb_data_d;
  logic         rb_valid_q, rb_valid_d;
  assign read_stall = posmatEnable | rbEnable;
`else
  assign read_stall = posmatEnable;
`endif

  // Gating with resetn ensures a burst being aborted by reset writes nothing
  assign load_ready  = resetn & (state_q == LOAD) & ~read_stall;
  assign beat_accept = loadValid & load_ready;
  assign row_base    = {posmatAddr[5:0], 2'b00};

  assign loadReady   = load_ready;
  assign loadBusy    = (state_q == LOAD);
  assign posmatData  = posmat_data_q;
  assign posmatValid = posmat_valid_q;

  // Burst control: latch start address and length, then walk the pointer per accepted beat
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    if (state_q == IDLE) begin
      if (loadStart) begin
        wr_ptr_d   = loadAddr;
        beat_cnt_d = loadCount;
        state_d    = LOAD;
      end
    end else if (beat_accept) begin
      wr_ptr_d = wr_ptr_q + 8'd1;
      if (beat_cnt_q == 4'd0) begin
        state_d = IDLE;
      end else begin
        beat_cnt_d = beat_cnt_q - 4'd1;
      end
    end
  end

  // Row read: out-of-range rows (posmatAddr[6] set) return zeros; data holds when idle
  always_comb begin
    posmat_valid_d = posmatEnable;
    posmat_data_d  = posmat_data_q;
    if (posmatEnable) begin
      if (posmatAddr[6]) begin
        posmat_data_d = '0;
      end else begin
        posmat_data_d = {mem_q[{row_base[7:2], 2'd0}], mem_q[{row_base[7:2], 2'd1}],
                         mem_q[{row_base[7:2], 2'd2}], mem_q[{row_base[7:2], 2'd3}]};
      end
    end
  end

  // Control and read-port registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= IDLE;
      wr_ptr_q       <= 8'd0;
      beat_cnt_q     <= 4'd0;
      posmat_data_q  <= '0;
      posmat_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      beat_cnt_q     <= beat_cnt_d;
      posmat_data_q  <= posmat_data_d;
      posmat_valid_q <= posmat_valid_d;
    end
  end

  // Storage array is deliberately not reset so matrices survive a reset
  always_ff @(posedge clk) begin
    if (beat_accept) begin
      mem_q[wr_ptr_q] <= loadData;
    end
  end

`ifdef XF_MATMEM_READBACK_EN
  assign rbData  = rb_data_q;
  assign rbValid = rb_valid_q;

  // Single-word readback, pre-empted by a row read in the same cycle
  always_comb begin
    rb_valid_d = rbEnable & ~posmatEnable;
    rb_data_d  = rb_data_q;
    if (rb_valid_d) begin
      rb_data_d = mem_q[rbAddr];
    end
  end

  // Readback registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rb_data_q  <= 32'd0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end
`endif

endmodule
